// File: rtl/keccak_pkg.sv
// keccak_pkg
//   Shared constants and types for the Keccak message-side path.
//   - SHAKE_DS_BYTE : domain-separation byte placed right after the message
//   - PAD_LAST_BYTE : final pad10*1 bit, lives in the last byte of a rate block
//   - RATE_SHAKE128 / RATE_SHAKE256 : supported rates in bits
//   - padder_state_t : keccak_padder FSM states
package keccak_pkg;

    localparam logic [7:0] SHAKE_DS_BYTE = 8'h1F;
    localparam logic [7:0] PAD_LAST_BYTE = 8'h80;

    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    typedef enum logic [1:0] {
        IDLE,
        ABSORB,
        ZFILL,
        LAST
    } padder_state_t;

endpackage

// File: rtl/pad_word_builder.sv
// pad_word_builder
//   Combinational builder for the word that carries the end of the message.
//   Bytes below n come from the message, byte n is the domain byte, the rest
//   are zero; when the word closes a rate block the final pad bit is OR-ed
//   into the top byte (so n = NB-1 at a block end yields 0x9F on top).
//   Ports:
//     data_i      : message word (little-endian bytes)
//     n_i         : number of valid message bytes in data_i (0..NB-1)
//     block_end_i : this word is the last word of the rate block
//     word_o      : padded word
module pad_word_builder
    import keccak_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0]             data_i,
    input  logic [$clog2(W/8)-1:0]   n_i,
    input  logic                     block_end_i,
    output logic [W-1:0]             word_o
);

    localparam int NB = W / 8;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            logic [7:0] base;

            // Compare in int so the top byte's "always false" test does not
            // collapse into a constant-range comparison.
            always_comb begin
                if (gi < int'(n_i)) begin
                    base = data_i[8*gi +: 8];
                end else if (gi == int'(n_i)) begin
                    base = SHAKE_DS_BYTE;
                end else begin
                    base = 8'h00;
                end
            end

            if (gi == NB - 1) begin : g_top
                assign word_o[8*gi +: 8] = base | (block_end_i ? PAD_LAST_BYTE : 8'h00);
            end else begin : g_low
                assign word_o[8*gi +: 8] = base;
            end
        end
    endgenerate

endmodule

// File: rtl/keccak_padder.sv
// keccak_padder
//   Message-side stage in front of the Keccak absorb datapath. Forwards
//   message words, appends SHAKE domain byte + pad10*1 and zero-fills to a
//   whole number of rate blocks.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     start           : begin a message (honoured only in IDLE)
//     block_size      : rate in bits, latched on start
//     remaining_bits  : message bits still to consume (from the size counter)
//     count_en        : steps the size counter; high in the same cycle as an
//                       input accept so the counter is current next cycle
//     in_valid/in_data/in_ready      : message word input handshake
//     out_valid/out_data/out_ready   : padded word output handshake
//     out_block_end   : output word closes a rate block
//     out_msg_end     : output word is the final word of the message
//     busy            : start until the final word is handed off
module keccak_padder
    import keccak_pkg::*;
#(
    parameter int W         = 64,
    parameter int CNT_WIDTH = 32,
    parameter int RATE_MAX  = RATE_SHAKE128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [10:0]          block_size,
    input  logic [CNT_WIDTH-1:0] remaining_bits,
    output logic                 count_en,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic                 out_block_end,
    output logic                 out_msg_end,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int NB    = W / 8;
    localparam int NW    = $clog2(NB);
    localparam int IDX_W = $clog2(RATE_MAX / W + 1);

    padder_state_t    state_q;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic             out_block_end_q;
    logic             out_msg_end_q;
    logic             busy_q;
    logic [IDX_W-1:0] word_idx_q;
    logic [IDX_W-1:0] wpb_q;

    logic             load_ok;
    logic             full_word;
    logic             block_end;
    logic [NW-1:0]    tail_bytes;
    logic [W-1:0]     pad_word;
    logic             in_ready_d;
    logic             load_d;
    logic             load_final_d;
    logic [W-1:0]     load_data_d;

    // The single output slot may be refilled when it is empty or being
    // drained this very cycle.
    assign load_ok    = !out_valid_q || out_ready;
    assign full_word  = remaining_bits >= CNT_WIDTH'(W);
    assign tail_bytes = NW'(remaining_bits >> 3);
    assign block_end  = (word_idx_q == wpb_q - IDX_W'(1));

    pad_word_builder #(
        .W (W)
    ) u_pad_word_builder (
        .data_i      (in_data),
        .n_i         (tail_bytes),
        .block_end_i (block_end),
        .word_o      (pad_word)
    );

    always_comb begin
        in_ready_d   = 1'b0;
        load_d       = 1'b0;
        load_final_d = 1'b0;
        load_data_d  = '0;
        case (state_q)
            ABSORB: begin
                if (full_word) begin
                    // A word of exactly W bits is plain pass-through; the
                    // padding then starts in the following word.
                    in_ready_d  = load_ok;
                    load_d      = in_valid && load_ok;
                    load_data_d = in_data;
                end else if (tail_bytes != '0) begin
                    in_ready_d   = load_ok;
                    load_d       = in_valid && load_ok;
                    load_data_d  = pad_word;
                    load_final_d = block_end;
                end else begin
                    // Nothing left to consume: the pad word is generated
                    // without taking an input word.
                    load_d       = load_ok;
                    load_data_d  = pad_word;
                    load_final_d = block_end;
                end
            end
            ZFILL: begin
                load_d       = load_ok;
                load_data_d  = block_end ? {PAD_LAST_BYTE, {(W-8){1'b0}}} : '0;
                load_final_d = block_end;
            end
            default: begin
            end
        endcase
        // Reset must not let the size counter step on the reset edge.
        if (rst) begin
            in_ready_d = 1'b0;
            load_d     = 1'b0;
        end
    end

    assign in_ready = in_ready_d;
    assign count_en = in_ready_d && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_block_end_q <= 1'b0;
            out_msg_end_q   <= 1'b0;
            busy_q          <= 1'b0;
            word_idx_q      <= '0;
            wpb_q           <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= ABSORB;
                        busy_q     <= 1'b1;
                        word_idx_q <= '0;
                        wpb_q      <= IDX_W'(block_size >> $clog2(W));
                    end
                end
                ABSORB: begin
                    // Leaving ABSORB only when the word holding the domain
                    // byte has been loaded.
                    if (load_d && !full_word) begin
                        state_q <= block_end ? LAST : ZFILL;
                    end
                end
                ZFILL: begin
                    if (load_d && block_end) begin
                        state_q <= LAST;
                    end
                end
                LAST: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load_d) begin
                out_valid_q     <= 1'b1;
                out_data_q      <= load_data_d;
                out_block_end_q <= block_end;
                out_msg_end_q   <= load_final_d;
                word_idx_q      <= block_end ? '0 : word_idx_q + IDX_W'(1);
            end else if (out_ready) begin
                out_valid_q     <= 1'b0;
                out_block_end_q <= 1'b0;
                out_msg_end_q   <= 1'b0;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_block_end = out_block_end_q;
    assign out_msg_end   = out_msg_end_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_keccak_padder.sv
// tb_keccak_padder
//   Directed table of messages applied to keccak_padder with a behavioural
//   size counter; every output word is compared against the padded byte
//   stream built independently here, plus hand constants per table entry.
`timescale 1ns/1ps
module tb_keccak_padder;
    import keccak_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] block_size;
    logic [31:0] remaining_bits;
    logic        count_en;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_block_end;
    logic        out_msg_end;
    logic        out_ready;
    logic        busy;

    always #5 clk = ~clk;

    keccak_padder dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .block_size     (block_size),
        .remaining_bits (remaining_bits),
        .count_en       (count_en),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_block_end  (out_block_end),
        .out_msg_end    (out_msg_end),
        .out_ready      (out_ready),
        .busy           (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] got [0:63];

    typedef struct {
        int          rate;
        int          len;
        int          seed;
        int          step;
        bit          rnd;
        int          exp_words;
        int          exp_cnt;
        logic [63:0] exp_first;
        logic [63:0] exp_last;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] msg_byte(int i, int seed, int step);
        return 8'(seed + i * step);
    endfunction

    // Input word k; bytes past the message end carry junk the padder must drop.
    function automatic logic [63:0] drive_word(int k, int nbytes, int seed, int step);
        logic [63:0] w;
        int i;
        for (int b = 0; b < 8; b++) begin
            i = 8 * k + b;
            w[8*b +: 8] = (i < nbytes) ? msg_byte(i, seed, step) : 8'hA5;
        end
        return w;
    endfunction

    // Reference padded stream: message, 0x1F, zeros, 0x80 in the last byte.
    function automatic logic [63:0] exp_word(int j, int nbytes, int total, int seed, int step);
        logic [63:0] w;
        logic [7:0]  bv;
        int i;
        for (int b = 0; b < 8; b++) begin
            i = 8 * j + b;
            if (i < nbytes)       bv = msg_byte(i, seed, step);
            else if (i == nbytes) bv = 8'h1F;
            else                  bv = 8'h00;
            if (i == total - 1)   bv = bv | 8'h80;
            w[8*b +: 8] = bv;
        end
        return w;
    endfunction

    task automatic run_msg(input int rate, input int len, input int seed, input int step,
                           input bit rnd, input int abort, output int nw, output int nc);
        int nbytes, rb, total, nin, k, cyc;
        bit done, stall;
        logic [63:0] held;
        logic [31:0] rem_n;
        nbytes = len / 8;
        rb     = rate / 8;
        total  = ((nbytes + 1 + rb - 1) / rb) * rb;
        nin    = (len + 63) / 64;
        k = 0; cyc = 0; done = 0; stall = 0; held = '0;
        nw = 0; nc = 0;
        block_size     = 11'(rate);
        remaining_bits = 32'(len);
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && cyc < 3000) begin
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (k < nin);
            in_data   = drive_word(k, nbytes, seed, step);
            @(negedge clk);
            if (stall) begin
                chk("stall_data", out_data, held);
                chk("stall_valid", 64'(out_valid), 64'd1);
            end
            stall = out_valid && !out_ready;
            held  = out_data;
            rem_n = remaining_bits;
            if (count_en) begin
                nc++;
                rem_n = (remaining_bits >= 32'd64) ? remaining_bits - 32'd64 : 32'd0;
            end
            if (in_valid && in_ready) k++;
            if (out_valid && out_ready) begin
                chk($sformatf("word%0d", nw), out_data, exp_word(nw, nbytes, total, seed, step));
                chk($sformatf("blk_end%0d", nw), 64'(out_block_end),
                    64'(((nw + 1) % (rate / 64)) == 0));
                chk($sformatf("msg_end%0d", nw), 64'(out_msg_end), 64'(nw == total / 8 - 1));
                if (nw < 64) got[nw] = out_data;
                nw++;
                if (out_msg_end) done = 1;
            end
            @(posedge clk); #1;
            remaining_bits = rem_n;
            if (abort > 0 && nc == abort) return;
        end
        chk("finished", 64'(done), 64'd1);
        chk("busy_fall", 64'(busy), 64'd0);
        chk("idle_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int nw, nc;

        vecs[0] = '{1344,    0, 'h01, 'h01, 1'b0, 21,  0, 64'h1F,               64'h8000000000000000};
        vecs[1] = '{1088,   24, 'hEF, 'hDE, 1'b0, 17,  1, 64'h1FABCDEF,         64'h8000000000000000};
        vecs[2] = '{1088, 1088, 'h01, 'h01, 1'b0, 34, 17, 64'h0807060504030201, 64'h8000000000000000};
        vecs[3] = '{1344, 1336, 'h01, 'h01, 1'b0, 21, 21, 64'h0807060504030201, 64'h9FA7A6A5A4A3A2A1};
        vecs[4] = '{1344,  200, 'h01, 'h01, 1'b1, 21,  4, 64'h0807060504030201, 64'h8000000000000000};
        vecs[5] = '{1088, 1000, 'h01, 'h01, 1'b1, 17, 16, 64'h0807060504030201, 64'h8000000000000000};
        vecs[6] = '{1088,   64, 'h01, 'h01, 1'b0, 17,  1, 64'h0807060504030201, 64'h8000000000000000};

        rst = 1'b1; start = 1'b0; block_size = 11'(RATE_SHAKE128);
        remaining_bits = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", {62'd0, out_block_end, out_msg_end}, 64'd0);
        chk("rst_count_en", 64'(count_en), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++) begin
            run_msg(vecs[t].rate, vecs[t].len, vecs[t].seed, vecs[t].step, vecs[t].rnd, 0, nw, nc);
            $display("msg %0d: rate=%0d len=%0d words=%0d count_en=%0d", t, vecs[t].rate,
                     vecs[t].len, nw, nc);
            chk($sformatf("v%0d_words", t), 64'(nw), 64'(vecs[t].exp_words));
            chk($sformatf("v%0d_count_en", t), 64'(nc), 64'(vecs[t].exp_cnt));
            chk($sformatf("v%0d_first", t), got[0], vecs[t].exp_first);
            chk($sformatf("v%0d_last", t), got[vecs[t].exp_words - 1], vecs[t].exp_last);
            if (t == 2) chk("v2_extra_pad", got[17], 64'h1F);
            if (t == 6) chk("v6_pad_word", got[1], 64'h1F);
            @(posedge clk); #1;
        end

        // Reset in the middle of a message, then a clean 8-bit message.
        run_msg(1344, 1000, 'h03, 'h07, 1'b0, 5, nw, nc);
        $display("abort: words=%0d count_en=%0d", nw, nc);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mid_count_en", 64'(count_en), 64'd0);
        @(posedge clk); #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_data", out_data, 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_flags", {62'd0, out_block_end, out_msg_end}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        run_msg(1344, 8, 'h5A, 'h01, 1'b0, 0, nw, nc);
        $display("after reset: words=%0d count_en=%0d", nw, nc);
        chk("post_rst_words", 64'(nw), 64'd21);
        chk("post_rst_count_en", 64'(nc), 64'd1);
        chk("post_rst_first", got[0], 64'h1F5A);
        chk("post_rst_last", got[20], 64'h8000000000000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
